// File: rtl/fpu_dispatch_pkg.sv
// Shared FPU instruction encoding and flag bit positions used by the dispatch
// queue and anything that consumes its writeback flags.
package fpu_dispatch_pkg;

    typedef enum logic [2:0] {
        FPU_ADD,
        FPU_SUB,
        FPU_MUL,
        FPU_DIV,
        FPU_SQRT,
        FPU_CMP,
        FPU_FLAGS,
        FPU_NEG
    } FPUInstruction;

    // Bit positions inside the packed {z,n,c,o} flag nibble.
    localparam int unsigned FPU_FLAG_Z = 3;
    localparam int unsigned FPU_FLAG_N = 2;
    localparam int unsigned FPU_FLAG_C = 1;
    localparam int unsigned FPU_FLAG_O = 0;
    localparam int unsigned FPU_FLAG_W = 4;

    // Ops whose writeback payload is the flag nibble, not the result word.
    function automatic logic is_flags_op(input FPUInstruction inst);
        return (inst == FPU_CMP) || (inst == FPU_FLAGS);
    endfunction

endpackage

// File: rtl/fpu_dispatch_fifo.sv
// In-order circular queue with a combinational head read port and explicit count.
// DEPTH must be a power of two so the pointers wrap on their natural width.
module fpu_dispatch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) begin
            tail_d = tail_q + PtrW'(1);
        end
        if (do_pop) begin
            head_d = head_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Queues FPU ops, launches them one at a time and holds the tagged result and
// flags for writeback until the consumer accepts them.
module fpu_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  FPUInstruction          i_inst,
    input  logic [63:0]            i_data0,
    input  logic [63:0]            i_data1,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_fpu_start,
    output FPUInstruction          o_fpu_inst,
    output logic [63:0]            o_fpu_data0,
    output logic [63:0]            o_fpu_data1,
    input  logic [63:0]            i_fpu_result,
    input  logic                   i_fpu_wait,
    input  logic                   i_fpu_finished,
    input  logic                   i_fpu_z,
    input  logic                   i_fpu_n,
    input  logic                   i_fpu_c,
    input  logic                   i_fpu_o,
    output logic                   o_wb_valid,
    input  logic                   i_wb_ready,
    output logic [TAG_W-1:0]       o_wb_tag,
    output logic [63:0]            o_wb_result,
    output logic [FPU_FLAG_W-1:0]  o_wb_flags,
    output logic                   o_wb_is_flags,
    output logic [$clog2(DEPTH):0] o_count
);

    typedef struct packed {
        FPUInstruction    inst;
        logic [63:0]      data0;
        logic [63:0]      data1;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StWb} state_e;

    state_e                state_q;
    logic                  start_q;
    logic                  wb_valid_q;
    logic [TAG_W-1:0]      wb_tag_q;
    logic [63:0]           wb_result_q;
    logic [FPU_FLAG_W-1:0] wb_flags_q;
    logic                  wb_is_flags_q;

    entry_t push_entry, head_entry;
    logic   push, pop, fifo_full, fifo_empty;
    logic   unused_wait;

    assign unused_wait = i_fpu_wait;

    assign push_entry = '{inst: i_inst, data0: i_data0, data1: i_data1, tag: i_tag};
    assign o_ready    = ~fifo_full;
    assign push       = i_valid & ~fifo_full;
    // The head is retired the moment its result is captured.
    assign pop        = (state_q == StBusy) & i_fpu_finished;

    fpu_dispatch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(entry_t))
    ) u_fifo (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .push_i (push),
        .wdata_i(push_entry),
        .pop_i  (pop),
        .rdata_o(head_entry),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(o_count)
    );

    // Operands come straight from the head, so they stay put until the pop.
    assign o_fpu_inst  = head_entry.inst;
    assign o_fpu_data0 = head_entry.data0;
    assign o_fpu_data1 = head_entry.data1;

    assign o_fpu_start   = start_q;
    assign o_wb_valid    = wb_valid_q;
    assign o_wb_tag      = wb_tag_q;
    assign o_wb_result   = wb_result_q;
    assign o_wb_flags    = wb_flags_q;
    assign o_wb_is_flags = wb_is_flags_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            start_q       <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_tag_q      <= '0;
            wb_result_q   <= '0;
            wb_flags_q    <= '0;
            wb_is_flags_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StIssue;
                        start_q <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q <= StBusy;
                end
                StBusy: begin
                    if (i_fpu_finished) begin
                        wb_valid_q             <= 1'b1;
                        wb_tag_q               <= head_entry.tag;
                        wb_result_q            <= i_fpu_result;
                        wb_flags_q[FPU_FLAG_Z] <= i_fpu_z;
                        wb_flags_q[FPU_FLAG_N] <= i_fpu_n;
                        wb_flags_q[FPU_FLAG_C] <= i_fpu_c;
                        wb_flags_q[FPU_FLAG_O] <= i_fpu_o;
                        wb_is_flags_q          <= is_flags_op(head_entry.inst);
                        state_q                <= StWb;
                    end
                end
                StWb: begin
                    // Count already reflects the pop done on the finish cycle.
                    if (i_wb_ready) begin
                        wb_valid_q <= 1'b0;
                        if (!fifo_empty) begin
                            state_q <= StIssue;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    finish_only_in_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_fpu_finished |-> (state_q == StBusy))
        else $error("fpu_dispatch: finish pulse outside BUSY ignored");
`endif

endmodule
